fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/mips_pkg.sv | 25 ++
 rtl/next_pc_calc.sv | 31 +++
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-side definitions: next-PC select encodings, fetch FSM state type and reset PC.
// ST_HALT exists only when FETCH_TIMEOUT_EN is defined.
package mips_pkg;

  typedef logic [1:0] pc_src_t;
  localparam pc_src_t PC_SEQ    = 2'b00;
  localparam pc_src_t PC_JR     = 2'b01;
  localparam pc_src_t PC_JUMP   = 2'b10;
  localparam pc_src_t PC_BRANCH = 2'b11;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_IDLE = 2'd0;
  localparam fetch_state_t ST_WAIT = 2'd1;
  localparam fetch_state_t ST_EXEC = 2'd2;
`ifdef FETCH_TIMEOUT_EN
  localparam fetch_state_t ST_HALT = 2'd3;
`endif

  localparam logic [31:0] MIPS_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, register jump, pseudo-direct jump and PC-relative branch.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] jr_target,
  input  pc_src_t     pc_src,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic unused_bits;

  assign pc_plus4 = pc + 32'd4;

  // Opcode bits and the low jr_target bits never influence the target address.
  assign unused_bits = ^{instr[31:26], jr_target[1:0]};

  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      PC_SEQ:    next_pc = pc_plus4;
      PC_JR:     next_pc = {jr_target[31:2], 2'b00};
      PC_JUMP:   next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      PC_BRANCH: next_pc = pc_plus4 + branch_offset(instr[15:0]);
      default:   next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM (IDLE -> WAIT -> EXEC) holding the PC and the instruction register.
// Define FETCH_TIMEOUT_EN to add the WAIT timeout counter, HALT state and fetch_err output.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = MIPS_RESET_PC,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc_plus4,
  input  pc_src_t     pc_src,
  input  logic [31:0] jr_target,
  input  logic        hold
`ifdef FETCH_TIMEOUT_EN
  ,output logic       fetch_err
`endif
);

  // The wait counter is 8 bits wide, so the limit must be reachable by it.
  if (TIMEOUT_CYC == 0 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("fetch_unit: TIMEOUT_CYC must be in 1..255");
  end

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  next_pc;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  next_pc_calc u_next_pc_calc (
    .pc        (pc_q),
    .instr     (instr_q),
    .jr_target (jr_target),
    .pc_src    (pc_src),
    .pc_plus4  (pc_plus4),
    .next_pc   (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        state_d = ST_WAIT;
`ifdef FETCH_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end
      ST_WAIT: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_EXEC;
        end
`ifdef FETCH_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TIMEOUT_LIM) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
          end
        end
`endif
      end
      // pc_src and jr_target only matter on the cycle hold is low.
      ST_EXEC: begin
        if (!hold) begin
          pc_d    = next_pc;
          state_d = ST_IDLE;
        end
      end
`ifdef FETCH_TIMEOUT_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Gating with rst lets the request drop immediately when reset hits mid-WAIT.
  assign imem_req    = !rst && (state_q == ST_IDLE || state_q == ST_WAIT);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == ST_EXEC);
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err   = err_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: sequential flow, jumps, branches, stalls, wrap and reset.
// Timeout/HALT checks are included when FETCH_TIMEOUT_EN is defined.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc_plus4;
  logic [1:0]  pc_src;
  logic [31:0] jr_target;
  logic        hold;
`ifdef FETCH_TIMEOUT_EN
  logic        fetch_err;
`endif

  int checkCount = 0;
  int errorCount = 0;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc_plus4   (pc_plus4),
    .pc_src     (pc_src),
    .jr_target  (jr_target),
    .hold       (hold)
`ifdef FETCH_TIMEOUT_EN
    ,.fetch_err (fetch_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // One full fetch: find the IDLE request, ack after ackDelay WAIT cycles, stall holdCycles, then commit.
  task automatic applyStimulus(input string tag, input logic [31:0] expAddr, input logic [31:0] word,
                               input int ackDelay, input int holdCycles,
                               input logic [1:0] src, input logic [31:0] jr);
    int waitCnt;
    int validCnt;
    waitCnt = 0;
    while (!imem_req && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!imem_req) begin
      checkOutput({tag, "_req_wait"}, 32'(imem_req), 32'd1);
      return;
    end
    checkOutput({tag, "_addr"}, imem_addr, expAddr);
    @(negedge clk);
    for (int i = 0; i < ackDelay; i++) begin
      imem_ack = 1'b0;
      @(negedge clk);
    end
    checkOutput({tag, "_wait_req"}, 32'(imem_req), 32'd1);
    checkOutput({tag, "_wait_addr"}, imem_addr, expAddr);
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack = 1'b0;
    validCnt = 0;
    if (instr_valid) validCnt++;
    checkOutput({tag, "_instr"}, instr, word);
    checkOutput({tag, "_req_low"}, 32'(imem_req), 32'd0);
    checkOutput({tag, "_pc_plus4"}, pc_plus4, expAddr + 32'd4);
    for (int i = 0; i < holdCycles; i++) begin
      hold       = 1'b1;
      pc_src     = ~src;
      jr_target  = 32'h1234_5678;
      imem_ack   = 1'b1;
      imem_rdata = ~word;
      @(negedge clk);
      if (instr_valid) validCnt++;
      checkOutput({tag, "_hold_instr"}, instr, word);
      checkOutput({tag, "_hold_addr"}, imem_addr, expAddr);
    end
    checkOutput({tag, "_valid_cycles"}, 32'(validCnt), 32'(holdCycles + 1));
    imem_ack  = 1'b0;
    hold      = 1'b0;
    pc_src    = src;
    jr_target = jr;
    @(negedge clk);
    checkOutput({tag, "_valid_drop"}, 32'(instr_valid), 32'd0);
    pc_src    = 2'b11;
    jr_target = 32'hDEAD_BEE0;
  endtask

  initial begin
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    pc_src     = 2'b00;
    jr_target  = 32'd0;
    hold       = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_instr", instr, 32'd0);
    checkOutput("rst_pc", imem_addr, 32'd0);
`ifdef FETCH_TIMEOUT_EN
    checkOutput("rst_err", 32'(fetch_err), 32'd0);
`endif
    imem_ack = 1'b0;
    rst      = 1'b0;
    #1;
    checkOutput("first_req", 32'(imem_req), 32'd1);

    applyStimulus("addi_seq",  32'h0000_0000, 32'h2008_0005, 0, 0, 2'b00, 32'd0);
    applyStimulus("jr_to_40",  32'h0000_0004, 32'h0000_0000, 0, 0, 2'b01, 32'h0000_0043);
    applyStimulus("beq_back",  32'h0000_0040, 32'h1000_FFFE, 0, 0, 2'b11, 32'd0);
    applyStimulus("jr_high",   32'h0000_003C, 32'h0000_0000, 0, 0, 2'b01, 32'h1000_0000);
    applyStimulus("j_region",  32'h1000_0000, 32'h0800_0010, 0, 0, 2'b10, 32'd0);
    applyStimulus("jr_203",    32'h1000_0040, 32'h0000_0008, 0, 0, 2'b01, 32'h0000_0203);
    applyStimulus("stall",     32'h0000_0200, 32'h0000_0020, 5, 3, 2'b00, 32'd0);
    applyStimulus("jr_top",    32'h0000_0204, 32'h0000_0000, 0, 0, 2'b01, 32'hFFFF_FFFF);
    applyStimulus("wrap",      32'hFFFF_FFFC, 32'h0000_0000, 1, 0, 2'b00, 32'd0);

    checkOutput("wrap_addr", imem_addr, 32'd0);
    @(negedge clk);
    checkOutput("midwait_req", 32'(imem_req), 32'd1);
    #2;
    rst      = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    #1;
    checkOutput("midwait_req_drop", 32'(imem_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("restart_req", 32'(imem_req), 32'd1);
    @(negedge clk);
    imem_ack = 1'b0;
    checkOutput("late_ack_ignored", 32'(instr_valid), 32'd0);
    checkOutput("restart_addr", imem_addr, 32'd0);
    checkOutput("restart_instr", instr, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h2009_0001;
    @(negedge clk);
    imem_ack = 1'b0;
    checkOutput("restart_exec_instr", instr, 32'h2009_0001);
    pc_src = 2'b00;
    @(negedge clk);
    applyStimulus("after_rst", 32'h0000_0004, 32'h0000_0000, 0, 0, 2'b00, 32'd0);

`ifdef FETCH_TIMEOUT_EN
    @(negedge clk);
    imem_ack = 1'b0;
    repeat (250) @(negedge clk);
    checkOutput("to_not_yet", 32'(fetch_err), 32'd0);
    repeat (10) @(negedge clk);
    checkOutput("to_err", 32'(fetch_err), 32'd1);
    checkOutput("to_req", 32'(imem_req), 32'd0);
    imem_ack = 1'b1;
    repeat (5) @(negedge clk);
    imem_ack = 1'b0;
    checkOutput("halt_sticky", 32'(fetch_err), 32'd1);
    checkOutput("halt_valid", 32'(instr_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("halt_rst_err", 32'(fetch_err), 32'd0);
    checkOutput("halt_rst_req", 32'(imem_req), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
